dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the Mips core's load/store port. It is the target end of the CPU's memory request interface.
- Accepts one request at a time over a valid/ready handshake and models a configurable access latency.
- Performs byte, half and word accesses, little-endian, with sign or zero extension on loads.
- Flags misaligned and out-of-range accesses. Sits beside Mips inside the top level, driven by the same clk/rst.

Parameters:
- ADDR_W, 10, word-address bits; memory holds 2**ADDR_W 32-bit words (4 KiB default).
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the byte/half is taken from the low lanes.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and raises err.
- req_unsigned  input  1  load zero-extends when 1 (lbu/lhu).
- resp_valid  output  1  one-cycle pulse, response ready.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; misaligned, out of range, or illegal size.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Memory array: not cleared by rst; zero-initialised at time 0 in simulation.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid at an edge, latch we/addr/wdata/size/unsigned and load the counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. Decrement the counter; go to RESP when the counter reaches 1.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. There is no backpressure: the CPU must sample in that cycle.
- Timing: a request accepted at edge T produces resp_valid high during the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance. Throughput is one access per LATENCY+1 cycles.
- Store commit: the array write happens at the edge leaving RESP. A load issued immediately after a store to the same address returns the new data.
- Error check, computed at acceptance:
  - half with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - addr[31:ADDR_W+2]!=0 is an error;
  - size=11 is an error.
  - On error: no write, resp_rdata=0, resp_err=1.
- Lane mapping (little-endian): byte lane k = bits 8k+7:8k, selected by addr[1:0]. Half lane selected by addr[1].
- Load extension:
  - byte: sign-extend bit 7 unless req_unsigned.
  - half: sign-extend bit 15 unless req_unsigned.
  - word: req_unsigned is ignored.
- Store masking: only the addressed bytes of the word are modified; all other bytes are preserved.
- Output hold: resp_rdata and resp_err keep their last values after the pulse, until the next RESP.
- req_valid outside IDLE is ignored; the request is not queued.
- rst mid-operation: in WAIT or RESP, the next edge returns to IDLE. The pending store is discarded (array unchanged) and no resp_valid is emitted.
- Wrap-around: the counter never wraps, because LATENCY is bounded at elaboration. The word index is addr[ADDR_W+1:2]; no aliasing, since upper bits are rejected.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - FSM state encoding ST_IDLE, ST_WAIT, ST_RESP;
  - a MAX_LATENCY=15 constant.
- One sub-module, dmem_lane_align (combinational): given addr[1:0], size, unsigned, the read word and the write data, it produces
  - the extended load value,
  - the 4-bit byte write-enable,
  - the lane-shifted write word.
- The top level keeps the FSM, counter, request latch and array.

Test Plan:
- LATENCY=2, reset, then sw 0xDEADBEEF @0x10, then lw @0x10:
  - store response: resp_err=0, resp_rdata=0;
  - load: resp_rdata=0xDEADBEEF, with resp_valid exactly 2 cycles after the accepting edge;
  - req_ready low for 2 cycles per access.
- After the word above, sb 0x7F @0x11, then lb @0x11 and lw @0x10:
  - lb returns 0x0000007F;
  - lw returns 0xDEAD7FEF.
- Byte @0x13 = 0xDE:
  - lb returns 0xFFFFFFDE, lbu returns 0x000000DE;
  - lh @0x12 returns 0xFFFFDEAD, lhu returns 0x0000DEAD.
- Error cases:
  - lw @0x12 → resp_err=1, rdata=0;
  - sh @0x13 → resp_err=1, and a following lw @0x10 shows the word unchanged;
  - lw @0x00001000 (ADDR_W=10) → resp_err=1.
- Assert rst during WAIT of sw 0x12345678 @0x20:
  - no resp_valid; req_ready=1 the cycle after reset;
  - a following lw @0x20 returns the prior value 0x00000000.
- LATENCY=1 back-to-back with req_valid held high:
  - accepted on alternating edges;
  - resp_valid pulses every 2nd cycle;
  - requests presented while req_ready=0 are not accepted.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the data-memory responder: access-size
//               codes, FSM state encoding, latency bound and an alignment
//               helper used when a request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Latency bound; the counter is sized to hold it
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    // True when a half/word access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational little-endian lane steering for the responder.
//               Extracts and extends the addressed byte/half/word of a read
//               word, and builds the byte write-enable plus the replicated
//               write word for stores.
// Ports       : i_addr_lo  - byte offset within the word (addr[1:0])
//               i_size     - access size code
//               i_unsigned - zero-extend loads when set
//               i_rword    - memory word being read
//               i_wdata    - store data, payload in the low lanes
//               o_load     - extended load value
//               o_be       - per-byte write enable
//               o_wword    - store data shifted onto its lanes
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_load  = 32'd0;
        o_be    = 4'b0000;
        o_wword = 32'd0;
        case (i_size)
            SIZE_BYTE: begin
                o_load  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_be    = 4'b0001 << i_addr_lo;
                // Replicating across all lanes lets the enable pick the lane
                o_wword = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_load  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
            end
            SIZE_WORD: begin
                o_load  = i_rword;
                o_be    = 4'b1111;
                o_wword = i_wdata;
            end
            default: begin
                o_load  = 32'd0;
                o_be    = 4'b0000;
                o_wword = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory target for the CPU load/store port. Accepts one
//               request at a time (valid/ready), waits LATENCY cycles, then
//               pulses o_resp_valid for one cycle. Byte/half/word accesses,
//               little-endian, with sign/zero extension and error flagging
//               for misalignment, out-of-range addresses and illegal size.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_req_valid/o_req_ready - request handshake (ready in IDLE)
//               i_req_we          - 1 store, 0 load
//               i_req_addr        - byte address
//               i_req_wdata       - store data (low lanes)
//               i_req_size        - 00 byte, 01 half, 10 word, 11 illegal
//               i_req_unsigned    - zero-extend loads
//               o_resp_valid      - one-cycle response pulse
//               o_resp_rdata      - load result, held after the pulse
//               o_resp_err        - error flag, held after the pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    // Out-of-range LATENCY values are pinned to the legal 1..15 window so the
    // counter can never wrap.
    localparam int c_lat = (LATENCY < 1) ? 1 :
                           (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(c_lat - 1);
    localparam int c_depth = 1 << ADDR_W;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_cnt;

    // Latched request
    logic              r_we;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_req_err;

    // Response values kept visible after the pulse
    logic [31:0]       r_rdata_hold;
    logic              r_err_hold;

    logic [31:0]       r_mem [0:c_depth-1];

    logic              w_accept;
    logic              w_req_err;
    logic [31:0]       w_rword;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_resp_rdata;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

    // Error classification happens on the live request at acceptance.
    always_comb begin
        w_req_err = 1'b0;
        if (i_req_addr[31:ADDR_W+2] != '0)
            w_req_err = 1'b1;
        if (i_req_size == 2'b11)
            w_req_err = 1'b1;
        if (is_misaligned(i_req_size, i_req_addr[1:0]))
            w_req_err = 1'b1;
    end

    // ------------------------------------------------------------------
    // FSM: state register and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept)
                r_cnt <= c_cnt_load;
            else if (r_state == ST_WAIT)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid)
                    w_state_next = (c_lat == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                // Count of 1 here means this is the last WAIT cycle
                if (r_cnt == CNT_W'(1))
                    w_state_next = ST_RESP;
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. During RESP the response is driven live from the latched
    // request; afterwards the hold registers keep it stable.
    always_comb begin
        o_req_ready  = (r_state == ST_IDLE);
        o_resp_valid = (r_state == ST_RESP);
        o_resp_rdata = r_rdata_hold;
        o_resp_err   = r_err_hold;
        if (r_state == ST_RESP) begin
            o_resp_rdata = w_resp_rdata;
            o_resp_err   = r_req_err;
        end
    end

    // ------------------------------------------------------------------
    // Request latch (datapath, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= i_req_we;
            r_word_idx <= i_req_addr[ADDR_W+1:2];
            r_addr_lo  <= i_req_addr[1:0];
            r_wdata    <= i_req_wdata;
            r_size     <= i_req_size;
            r_uns      <= i_req_unsigned;
            r_req_err  <= w_req_err;
        end
    end

    assign w_rword = r_mem[r_word_idx];

    dmem_lane_align u_lane_align (
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_rword    (w_rword),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_be       (w_be),
        .o_wword    (w_wword)
    );

    // Stores and errored accesses return zero data
    assign w_resp_rdata = (r_req_err || r_we) ? 32'd0 : w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= 32'd0;
            r_err_hold   <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_rdata_hold <= w_resp_rdata;
            r_err_hold   <= r_req_err;
        end
    end

    // Store commit on the edge leaving RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_RESP) && r_we && !r_req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k])
                    r_mem[r_word_idx][8*k +: 8] <= w_wword[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire
